// File: rtl/hit_judge.sv
// rtl/hit_judge.sv - debounced button press judge producing hit/miss pulses
module hit_judge #(
   parameter int NUM_HOLES       = 4,
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int DB_WIDTH        = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 enable,
   input  logic [NUM_HOLES-1:0] btn_raw,
   input  logic [NUM_HOLES-1:0] mole_onehot,
   input  logic                 mole_new,
   output logic                 hit_pulse,
   output logic                 miss_pulse,
   output logic [NUM_HOLES-1:0] btn_level
);

   // Judge states: no mole, mole waiting for a whack, mole already scored.
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ARMED = 2'd1;
   localparam logic [1:0] SPENT = 2'd2;

   // Counter value at which the next differing cycle is the accepting one.
   localparam logic [DB_WIDTH-1:0] DB_LAST = DB_WIDTH'(DEBOUNCE_CYCLES - 1);

   logic [NUM_HOLES-1:0] sync_q1;
   logic [NUM_HOLES-1:0] sync_q2;
   logic [NUM_HOLES-1:0] level_q;
   logic [NUM_HOLES-1:0] level_d;
   logic [DB_WIDTH-1:0]  db_cnt [NUM_HOLES];
   logic [NUM_HOLES-1:0] press;
   logic                 press_any;
   logic                 press_match;
   logic                 mole_none;
   logic [1:0]           state;
   logic [1:0]           state_nxt;
   logic                 hit_nxt;
   logic                 miss_nxt;

   // Two-flop synchroniser for every raw button.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q1 <= '0;
         sync_q2 <= '0;
      end else begin
         sync_q1 <= btn_raw;
         sync_q2 <= sync_q1;
      end
   end

   // Per-button debouncer: level follows the input only after a full run of differing cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         level_q <= '0;
         for (int i = 0; i < NUM_HOLES; i++) begin
            db_cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_HOLES; i++) begin
            if (sync_q2[i] == level_q[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_LAST) begin
               db_cnt[i]  <= '0;
               level_q[i] <= sync_q2[i];
            end else begin
               db_cnt[i] <= db_cnt[i] + 1'b1;
            end
         end
      end
   end

   // Delayed copy of the debounced levels for rising-edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         level_d <= '0;
      end else begin
         level_d <= level_q;
      end
   end

   assign press       = level_q & ~level_d;
   assign press_any   = |press;
   assign press_match = |(press & mole_onehot);
   assign mole_none   = (mole_onehot == '0);
   assign btn_level   = level_q;

   // Next-state and pulse decision; a new mole overrides the current state and is judged at once.
   always_comb begin
      state_nxt = state;
      hit_nxt   = 1'b0;
      miss_nxt  = 1'b0;
      if (!enable) begin
         state_nxt = IDLE;
      end else if (mole_new) begin
         if (press_match) begin
            hit_nxt   = 1'b1;
            state_nxt = SPENT;
         end else begin
            miss_nxt  = press_any;
            state_nxt = ARMED;
         end
      end else begin
         case (state)
            IDLE: begin
               miss_nxt = press_any;
            end
            ARMED: begin
               if (mole_none) begin
                  state_nxt = IDLE;
                  miss_nxt  = press_any;
               end else if (press_match) begin
                  hit_nxt   = 1'b1;
                  state_nxt = SPENT;
               end else begin
                  miss_nxt = press_any;
               end
            end
            SPENT: begin
               if (mole_none) begin
                  state_nxt = IDLE;
                  miss_nxt  = press_any;
               end
            end
            default: begin
               state_nxt = IDLE;
            end
         endcase
      end
   end

   // State and registered output pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         hit_pulse  <= 1'b0;
         miss_pulse <= 1'b0;
      end else begin
         state      <= state_nxt;
         hit_pulse  <= hit_nxt;
         miss_pulse <= miss_nxt;
      end
   end

endmodule

// File: tb/tb_hit_judge.sv
// tb/tb_hit_judge.sv - self-checking bench for hit_judge
module tb_hit_judge;

   localparam int NH = 4;
   localparam int D  = 4;

   logic          clk;
   logic          rst_n;
   logic          enable;
   logic [NH-1:0] btn_raw;
   logic [NH-1:0] mole_onehot;
   logic          mole_new;
   logic          hit_pulse;
   logic          miss_pulse;
   logic [NH-1:0] btn_level;

   hit_judge #(.NUM_HOLES(NH), .DEBOUNCE_CYCLES(D), .DB_WIDTH(4)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .enable(enable),
      .btn_raw(btn_raw),
      .mole_onehot(mole_onehot),
      .mole_new(mole_new),
      .hit_pulse(hit_pulse),
      .miss_pulse(miss_pulse),
      .btn_level(btn_level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_pass;
   int n_total;
   int cnt_hit;
   int cnt_miss;

   // Reference model state: raw sample history, debounced level, mole appearance flags.
   logic [NH-1:0] m_q[$];
   logic [NH-1:0] m_level;
   logic [NH-1:0] m_level_prev;
   logic          m_hit;
   logic          m_miss;
   bit            m_live;
   bit            m_used;

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   task automatic model_reset();
      m_q.delete();
      for (int i = 0; i < D + 2; i++) m_q.push_back('0);
      m_level      = '0;
      m_level_prev = '0;
      m_hit        = 1'b0;
      m_miss       = 1'b0;
      m_live       = 0;
      m_used       = 0;
   endtask

   task automatic model_step();
      logic [NH-1:0] press;
      logic [NH-1:0] new_level;
      bit            all_diff;
      press = m_level & ~m_level_prev;
      m_q.push_back(btn_raw);
      new_level = m_level;
      // A level flips once the last D synchronised samples (raw delayed two clocks) all disagree with it.
      for (int b = 0; b < NH; b++) begin
         all_diff = 1;
         for (int j = 0; j < D; j++) begin
            if (m_q[m_q.size() - 3 - j][b] == m_level[b]) all_diff = 0;
         end
         if (all_diff) new_level[b] = ~m_level[b];
      end
      m_level_prev = m_level;
      m_level      = new_level;
      while (m_q.size() > D + 3) void'(m_q.pop_front());
      m_hit  = 1'b0;
      m_miss = 1'b0;
      if (!enable) begin
         m_live = 0;
      end else if (mole_new) begin
         m_live = 1;
         m_used = 0;
         if ((press & mole_onehot) != 0) begin
            m_hit  = 1'b1;
            m_used = 1;
         end else if (press != 0) begin
            m_miss = 1'b1;
         end
      end else if (!m_live || mole_onehot == 0) begin
         m_live = 0;
         if (press != 0) m_miss = 1'b1;
      end else if (!m_used) begin
         if ((press & mole_onehot) != 0) begin
            m_hit  = 1'b1;
            m_used = 1;
         end else if (press != 0) begin
            m_miss = 1'b1;
         end
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      @(negedge clk);
      check("hit_vs_model", hit_pulse, m_hit);
      check("miss_vs_model", miss_pulse, m_miss);
      check("level_vs_model", btn_level, m_level);
      check("hit_and_miss", hit_pulse & miss_pulse, 0);
      cnt_hit  += hit_pulse;
      cnt_miss += miss_pulse;
   endtask

   task automatic run_cycles(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   typedef struct {
      string         name;
      logic          en;
      logic          mnew;
      logic [NH-1:0] raw;
      logic [NH-1:0] mole;
      int            ncyc;
      int            hits;
      int            misses;
      logic [NH-1:0] level;
   } vec_t;

   vec_t tbl[25];

   initial begin
      int first;
      int rises;
      logic prev_lvl;

      n_pass = 0; n_total = 0; cnt_hit = 0; cnt_miss = 0;
      rst_n = 1'b0; enable = 1'b1; btn_raw = '0; mole_onehot = '0; mole_new = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      check("reset_hit", hit_pulse, 0);
      check("reset_miss", miss_pulse, 0);
      check("reset_level", btn_level, 0);
      rst_n = 1'b1;

      tbl[0]  = '{"t1_new_mole",      1, 1, 4'b0000, 4'b0100,  1, 0, 0, 4'b0000};
      tbl[1]  = '{"t1_press_hit",     1, 0, 4'b0100, 4'b0100, 10, 1, 0, 4'b0100};
      tbl[2]  = '{"t1_release",       1, 0, 4'b0000, 4'b0100, 10, 0, 0, 4'b0000};
      tbl[3]  = '{"t2_new_mole",      1, 1, 4'b0000, 4'b0001,  1, 0, 0, 4'b0000};
      tbl[4]  = '{"t2_wrong_hole",    1, 0, 4'b1000, 4'b0001, 10, 0, 1, 4'b1000};
      tbl[5]  = '{"t2_release",       1, 0, 4'b0000, 4'b0001, 10, 0, 0, 4'b0000};
      tbl[6]  = '{"t2_right_hole",    1, 0, 4'b0001, 4'b0001, 10, 1, 0, 4'b0001};
      tbl[7]  = '{"t2_release2",      1, 0, 4'b0000, 4'b0001, 10, 0, 0, 4'b0000};
      tbl[8]  = '{"t3_new_mole",      1, 1, 4'b0000, 4'b0010,  1, 0, 0, 4'b0000};
      tbl[9]  = '{"t3_first_whack",   1, 0, 4'b0010, 4'b0010, 10, 1, 0, 4'b0010};
      tbl[10] = '{"t3_release",       1, 0, 4'b0000, 4'b0010, 10, 0, 0, 4'b0000};
      tbl[11] = '{"t3_second_whack",  1, 0, 4'b0010, 4'b0010, 10, 0, 0, 4'b0010};
      tbl[12] = '{"t3_release2",      1, 0, 4'b0000, 4'b0010, 10, 0, 0, 4'b0000};
      tbl[13] = '{"t3_same_hole_new", 1, 1, 4'b0000, 4'b0010,  1, 0, 0, 4'b0000};
      tbl[14] = '{"t3_rewhack",       1, 0, 4'b0010, 4'b0010, 10, 1, 0, 4'b0010};
      tbl[15] = '{"t3_release3",      1, 0, 4'b0000, 4'b0010, 10, 0, 0, 4'b0000};
      tbl[16] = '{"t5_mole_off",      1, 0, 4'b0000, 4'b0000,  1, 0, 0, 4'b0000};
      tbl[17] = '{"t5_empty_whack",   1, 0, 4'b0010, 4'b0000, 10, 0, 1, 4'b0010};
      tbl[18] = '{"t5_release",       1, 0, 4'b0000, 4'b0000, 10, 0, 0, 4'b0000};
      tbl[19] = '{"t5_new_mole",      1, 1, 4'b0000, 4'b1000,  1, 0, 0, 4'b0000};
      tbl[20] = '{"t5_simul_press",   1, 0, 4'b1001, 4'b1000, 10, 1, 0, 4'b1001};
      tbl[21] = '{"t5_release",       1, 0, 4'b0000, 4'b1000, 10, 0, 0, 4'b0000};
      tbl[22] = '{"t6_press_disabled",0, 0, 4'b0001, 4'b1000, 10, 0, 0, 4'b0001};
      tbl[23] = '{"t6_enable_held",   1, 0, 4'b0001, 4'b1000, 10, 0, 0, 4'b0001};
      tbl[24] = '{"t6_release",       1, 0, 4'b0000, 4'b1000, 10, 0, 0, 4'b0000};

      for (int i = 0; i < 25; i++) begin
         enable = tbl[i].en; btn_raw = tbl[i].raw; mole_onehot = tbl[i].mole; mole_new = tbl[i].mnew;
         cnt_hit = 0; cnt_miss = 0;
         for (int c = 0; c < tbl[i].ncyc; c++) begin
            cycle();
            mole_new = 1'b0;
         end
         check({tbl[i].name, "_hits"}, cnt_hit, tbl[i].hits);
         check({tbl[i].name, "_misses"}, cnt_miss, tbl[i].misses);
         check({tbl[i].name, "_level"}, btn_level, tbl[i].level);
      end

      // Latency from raw edge to hit pulse.
      mole_onehot = 4'b0100; mole_new = 1'b1; cycle(); mole_new = 1'b0;
      btn_raw = 4'b0100; first = 0;
      for (int n = 1; n <= 12; n++) begin
         cycle();
         if (hit_pulse && first == 0) first = n;
      end
      check("latency", first, D + 3);
      btn_raw = '0; run_cycles(10);

      // Bounce on button 0 followed by a steady press.
      mole_onehot = 4'b0001; mole_new = 1'b1; cycle(); mole_new = 1'b0;
      cnt_hit = 0; cnt_miss = 0; rises = 0; prev_lvl = btn_level[0];
      for (int i = 0; i < 35; i++) begin
         btn_raw[0] = (i >= 20) ? 1'b1 : (((i / 2) % 2) == 0);
         cycle();
         if (btn_level[0] && !prev_lvl) rises++;
         prev_lvl = btn_level[0];
      end
      check("bounce_rises", rises, 1);
      check("bounce_pulses", cnt_hit + cnt_miss, 1);
      btn_raw = '0; run_cycles(10);

      // Randomised play against the reference model.
      for (int i = 0; i < 3000; i++) begin
         for (int b = 0; b < NH; b++) if ($urandom_range(0, 15) == 0) btn_raw[b] = ~btn_raw[b];
         mole_new = 1'b0;
         if ($urandom_range(0, 19) == 0) begin
            mole_new = 1'b1;
            case ($urandom_range(0, 9))
               0:       mole_onehot = '0;
               1:       mole_onehot = NH'($urandom);
               default: mole_onehot = NH'(1) << $urandom_range(0, NH - 1);
            endcase
         end else if ($urandom_range(0, 39) == 0) begin
            mole_onehot = '0;
         end
         if ($urandom_range(0, 99) == 0) enable = ~enable;
         cycle();
      end

      // Reset during a pulse, then during a debounce run.
      enable = 1'b1; mole_new = 1'b0; mole_onehot = '0; btn_raw = '0;
      run_cycles(8);
      btn_raw = 4'b0010;
      run_cycles(D + 3);
      check("pre_reset_miss", miss_pulse, 1);
      check("pre_reset_level", btn_level, 4'b0010);
      #2 rst_n = 1'b0;
      #1;
      check("reset_async_miss", miss_pulse, 0);
      check("reset_async_level", btn_level, 0);
      model_reset();
      btn_raw = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      btn_raw = 4'b0001;
      run_cycles(3);
      #2 rst_n = 1'b0;
      #1;
      check("reset_mid_db_hit", hit_pulse, 0);
      check("reset_mid_db_miss", miss_pulse, 0);
      check("reset_mid_db_level", btn_level, 0);
      model_reset();
      btn_raw = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      cnt_hit = 0; cnt_miss = 0;
      run_cycles(15);
      check("post_reset_pulses", cnt_hit + cnt_miss, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
